// File: rtl/alu_wb_arb_pkg.sv
// Shared defaults and index type for the ALU writeback write-port arbiter.
package alu_wb_arb_pkg;

  localparam int DEFAULT_NUM_ALU      = 5;
  localparam int DEFAULT_ID_W         = 3;
  localparam int DEFAULT_STARVE_LIMIT = 8;
  localparam int DEFAULT_CNT_W        = 4;

  typedef logic [DEFAULT_ID_W-1:0] alu_idx_t;

endpackage

// File: rtl/alu_wb_arbiter_if.sv
// Request/grant bundle between the ALU writeback queues, the LSU and the write-port arbiter.
interface alu_wb_arbiter_if #(
  parameter int NUM_ALU = alu_wb_arb_pkg::DEFAULT_NUM_ALU,
  parameter int ID_W    = alu_wb_arb_pkg::DEFAULT_ID_W
);

  logic [NUM_ALU-1:0] alu_entry_valid;
  logic               lsu_wr_req;
  logic [NUM_ALU-1:0] alu_entry_serviced;
  logic               alu_grant_valid;
  logic [ID_W-1:0]    alu_grant_id;
  logic               lsu_wr_stall;

  modport master (
    output alu_entry_valid, lsu_wr_req,
    input  alu_entry_serviced, alu_grant_valid, alu_grant_id, lsu_wr_stall
  );

  modport slave (
    input  alu_entry_valid, lsu_wr_req,
    output alu_entry_serviced, alu_grant_valid, alu_grant_id, lsu_wr_stall
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first valid index scanning from rr_ptr upward, modulo NUM_ALU.
module rr_priority_pick #(
  parameter int NUM_ALU = alu_wb_arb_pkg::DEFAULT_NUM_ALU,
  parameter int ID_W    = alu_wb_arb_pkg::DEFAULT_ID_W
) (
  input  logic [NUM_ALU-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  // Modulo wrap is done in int arithmetic so non-power-of-two NUM_ALU never yields an index >= NUM_ALU.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_ALU) idx = idx - NUM_ALU;
      if (!found && valid[idx]) begin
        found = 1'b1;
        index = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_wb_arbiter.sv
// Register-file write-port arbiter: LSU priority with starvation-forced round-robin ALU grants.
// Optional macro ALU_WB_ARB_PERF_CNT_EN adds registered grant performance counters.
module alu_wb_arbiter
  import alu_wb_arb_pkg::*;
#(
  parameter int NUM_ALU      = DEFAULT_NUM_ALU,
  parameter int ID_W         = DEFAULT_ID_W,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
`ifdef ALU_WB_ARB_PERF_CNT_EN
  output logic [31:0] perf_alu_grants,
  output logic [31:0] perf_forced_grants,
`endif
  alu_wb_arbiter_if.slave bus
);

  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] starve_cnt;
  logic             any_alu;
  logic             force_grant;
  logic             alu_grant;
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;

  rr_priority_pick #(
    .NUM_ALU (NUM_ALU),
    .ID_W    (ID_W)
  ) u_pick (
    .valid  (bus.alu_entry_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_idx)
  );

  assign any_alu     = |bus.alu_entry_valid;
  assign force_grant = bus.lsu_wr_req & any_alu & (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // All outputs are held quiet while reset is asserted, even though inputs may be active.
  assign alu_grant              = ~rst & pick_found & (~bus.lsu_wr_req | force_grant);
  assign bus.alu_grant_valid    = alu_grant;
  assign bus.alu_grant_id       = alu_grant ? pick_idx : '0;
  assign bus.alu_entry_serviced = alu_grant ? (NUM_ALU'(1) << pick_idx) : '0;
  assign bus.lsu_wr_stall       = ~rst & force_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (alu_grant) begin
        rr_ptr     <= (pick_idx == ID_W'(NUM_ALU-1)) ? '0 : pick_idx + 1'b1;
        starve_cnt <= '0;
      end else if (any_alu) begin
        if (starve_cnt != '1) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

`ifdef ALU_WB_ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_alu_grants    <= '0;
      perf_forced_grants <= '0;
    end else begin
      if (alu_grant)                perf_alu_grants    <= perf_alu_grants + 32'd1;
      if (alu_grant && force_grant) perf_forced_grants <= perf_forced_grants + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_arbiter.sv
// Directed bench for alu_wb_arbiter: vector table plus starvation, reset and wrap sequences.
module tb_alu_wb_arbiter;
  import alu_wb_arb_pkg::*;

  typedef struct {
    logic [4:0] valid;
    logic       lsu;
    logic [4:0] exp_srv;
    logic       exp_gv;
    alu_idx_t   exp_id;
    logic       exp_stall;
  } vec_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  vec_t vecs [12];

`ifdef ALU_WB_ARB_PERF_CNT_EN
  logic [31:0] perf_alu_grants;
  logic [31:0] perf_forced_grants;
`endif

  alu_wb_arbiter_if #(.NUM_ALU(5), .ID_W(3)) bus ();

  alu_wb_arbiter dut (
    .clk                (clk),
    .rst                (rst),
`ifdef ALU_WB_ARB_PERF_CNT_EN
    .perf_alu_grants    (perf_alu_grants),
    .perf_forced_grants (perf_forced_grants),
`endif
    .bus                (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] valid, input logic lsu);
    @(negedge clk);
    bus.alu_entry_valid = valid;
    bus.lsu_wr_req      = lsu;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] exp_srv, input logic exp_gv,
                             input alu_idx_t exp_id, input logic exp_stall);
    tests_run++;
    if ({bus.alu_entry_serviced, bus.alu_grant_valid, bus.alu_grant_id, bus.lsu_wr_stall} !==
        {exp_srv, exp_gv, exp_id, exp_stall}) begin
      tests_failed++;
      $display("[TB] FAIL %s: got srv=%b gv=%b id=%0d stall=%b, want srv=%b gv=%b id=%0d stall=%b",
               name, bus.alu_entry_serviced, bus.alu_grant_valid, bus.alu_grant_id,
               bus.lsu_wr_stall, exp_srv, exp_gv, exp_id, exp_stall);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst                 = 1'b1;
    bus.alu_entry_valid = 5'b11111;
    bus.lsu_wr_req      = 1'b0;

    vecs[0]  = '{5'b10100, 1'b0, 5'b00100, 1'b1, 3'd2, 1'b0};
    vecs[1]  = '{5'b10100, 1'b0, 5'b10000, 1'b1, 3'd4, 1'b0};
    vecs[2]  = '{5'b10100, 1'b0, 5'b00100, 1'b1, 3'd2, 1'b0};
    vecs[3]  = '{5'b10100, 1'b0, 5'b10000, 1'b1, 3'd4, 1'b0};
    vecs[4]  = '{5'b01000, 1'b0, 5'b01000, 1'b1, 3'd3, 1'b0};
    vecs[5]  = '{5'b11111, 1'b0, 5'b10000, 1'b1, 3'd4, 1'b0};
    vecs[6]  = '{5'b11111, 1'b0, 5'b00001, 1'b1, 3'd0, 1'b0};
    vecs[7]  = '{5'b11111, 1'b0, 5'b00010, 1'b1, 3'd1, 1'b0};
    vecs[8]  = '{5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0};
    vecs[9]  = '{5'b00010, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};
    vecs[10] = '{5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0};
    vecs[11] = '{5'b00100, 1'b0, 5'b00100, 1'b1, 3'd2, 1'b0};

    // Outputs stay quiet under reset even with every queue valid.
    #2;
    checkOutput("reset_quiet", 5'b00000, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].lsu);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_srv, vecs[i].exp_gv,
                  vecs[i].exp_id, vecs[i].exp_stall);
    end

    // Starvation with one ALU behind a busy LSU: forced grant every ninth cycle.
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(5'b00001, 1'b1);
      if (c % 9 == 0) checkOutput($sformatf("starve_c%0d", c), 5'b00001, 1'b1, 3'd0, 1'b1);
      else            checkOutput($sformatf("starve_c%0d", c), 5'b00000, 1'b0, 3'd0, 1'b0);
    end

    // Idle ALUs clear the counter, so the next episode starts fresh.
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(5'b00000, 1'b1);
      checkOutput($sformatf("idle_c%0d", c), 5'b00000, 1'b0, 3'd0, 1'b0);
    end
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(5'b00010, 1'b1);
      if (c == 9) checkOutput("fresh_force", 5'b00010, 1'b1, 3'd1, 1'b1);
      else        checkOutput($sformatf("fresh_c%0d", c), 5'b00000, 1'b0, 3'd0, 1'b0);
    end

    // Build rr_ptr=3 and starve_cnt=6, then reset asynchronously mid-cycle.
    applyStimulus(5'b00100, 1'b0);
    checkOutput("pre_rst_grant", 5'b00100, 1'b1, 3'd2, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(5'b00100, 1'b1);
      checkOutput($sformatf("pre_rst_c%0d", c), 5'b00000, 1'b0, 3'd0, 1'b0);
    end
    applyStimulus(5'b01001, 1'b0);
    checkOutput("pre_rst_rr3", 5'b01000, 1'b1, 3'd3, 1'b0);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_quiet", 5'b00000, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.lsu_wr_req = 1'b1;
    #1;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) applyStimulus(5'b01001, 1'b1);
      if (c == 9) checkOutput("post_rst_force", 5'b00001, 1'b1, 3'd0, 1'b1);
      else        checkOutput($sformatf("post_rst_c%0d", c), 5'b00000, 1'b0, 3'd0, 1'b0);
    end

`ifdef ALU_WB_ARB_PERF_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 18; c++) applyStimulus(5'b00001, 1'b1);
    @(posedge clk);
    #1;
    tests_run++;
    if (perf_alu_grants !== 32'd2 || perf_forced_grants !== 32'd2) begin
      tests_failed++;
      $display("[TB] FAIL perf: got alu=%0d forced=%0d, want alu=2 forced=2",
               perf_alu_grants, perf_forced_grants);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_wb_arbiter.md
Name: alu_wb_arbiter

Overview:
- Register-file write-port arbiter directly downstream of the ALU writeback queues.
- Receives rfa_queue_entry_valid from NUM_ALU ALU instances (4 SIMD + 1 SIMF by default).
- Each cycle, returns at most one one-hot rfa_queue_entry_serviced pulse, which pops the granted queue at the next clock edge.
- The LSU normally has write-port priority; a starvation counter periodically forces an ALU grant and stalls the LSU for one cycle.

Parameters:
- NUM_ALU, 5, number of ALU writeback queues arbitrated.
- ID_W, 3, width of the grant index; must satisfy 2^ID_W >= NUM_ALU.
- STARVE_LIMIT, 8, consecutive ALU-starved cycles before an ALU grant is forced over the LSU; legal range 1..2^CNT_W-1.
- CNT_W, 4, starvation counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- alu_entry_valid  input  NUM_ALU  per-ALU rfa_queue_entry_valid.
- lsu_wr_req  input  1  LSU requests the VGPR/SGPR write port this cycle.
- alu_entry_serviced  output  NUM_ALU  one-hot pop to the granted ALU queue (rfa_queue_entry_serviced).
- alu_grant_valid  output  1  some ALU holds the write port this cycle.
- alu_grant_id  output  ID_W  index of the granted ALU; 0 when alu_grant_valid=0.
- lsu_wr_stall  output  1  LSU is denied the write port this cycle.

Behaviour:
- State:
  - rr_ptr [ID_W], the highest-priority ALU index.
  - starve_cnt [CNT_W].
  - Both reset to 0 asynchronously.
- All outputs are combinational from the inputs and the registered state. Grant latency is zero: serviced is asserted in the same cycle the valid is seen, and the queue pops at the following edge.
- While rst=1: alu_entry_serviced=0, alu_grant_valid=0, alu_grant_id=0, lsu_wr_stall=0.
- any_alu = |alu_entry_valid.
- force = lsu_wr_req & any_alu & (starve_cnt >= STARVE_LIMIT).
- Grant decision each cycle:
  - No request (any_alu=0): no ALU grant, lsu_wr_stall=0.
  - LSU wins (lsu_wr_req=1, force=0): no ALU grant, lsu_wr_stall=0.
  - ALU grant (lsu_wr_req=0 or force=1), with any_alu=1: grant the first valid index scanning rr_ptr, rr_ptr+1, … modulo NUM_ALU. Set the one-hot serviced bit and grant id; lsu_wr_stall=force.
- rr_ptr update on any ALU grant to index i: rr_ptr <= i+1, wrapping from NUM_ALU-1 to 0. Unchanged when no ALU grant.
- starve_cnt update:
  - ALU grant: clear to 0.
  - LSU wins with any_alu=1: increment, saturating at 2^CNT_W-1.
  - any_alu=0: clear to 0.
- Each starvation episode therefore yields exactly one forced grant per STARVE_LIMIT+1 cycles.
- Valids may drop at any time with no handshake penalty; the arbiter never holds a grant across cycles.
- Reset asserted mid-episode: counter and pointer clear immediately; the first post-reset ALU grant goes to the lowest valid index.
- Out-of-range rr_ptr values cannot occur. The wrap logic must not emit an index >= NUM_ALU when NUM_ALU is not a power of two.

Optional Feature:
- Macro: ALU_WB_ARB_PERF_CNT_EN.
- Defined:
  - Adds output perf_alu_grants [32] and perf_forced_grants [32].
  - perf_alu_grants increments on every ALU grant; perf_forced_grants increments on every forced grant.
  - Both wrap at 2^32, reset to 0, and have 1-cycle latency (registered).
- Undefined: ports and counters are absent; the functional interface is identical.

Decomposition:
- Shared package (alu_wb_arb_pkg): NUM_ALU, ID_W, STARVE_LIMIT defaults, and the index type typedef.
- One natural sub-module: rr_priority_pick, a combinational rotate-and-find-first that takes the valid vector and rr_ptr and returns found and index.
- The counter, pointer and force logic stay in the top module.

Test Plan:
- Reset, then alu_entry_valid=5'b10100, lsu_wr_req=0, held for 4 cycles -> grants id 2, 4, 2, 4; serviced 00100, 10000, 00100, 10000; stall=0 throughout.
- rr_ptr=4 after a grant to 3, valid=5'b11111 -> next grant id 4, then 0 (wrap); never id 5–7.
- lsu_wr_req=1 and valid=5'b00001 held 20 cycles with STARVE_LIMIT=8 -> 8 LSU cycles, then 1 forced grant (stall=1, id 0), repeating: forced grants on cycles 9 and 18.
- lsu_wr_req=1 with valid=0 for 10 cycles, then valid=5'b00010 -> starve_cnt starts from 0; first forced grant arrives after 8 more cycles.
- rst pulsed asynchronously with starve_cnt=6 and rr_ptr=3, then valid=5'b01001 -> outputs are 0 during reset; first grant after reset is id 0.
- With ALU_WB_ARB_PERF_CNT_EN defined, run the third scenario for 18 cycles -> perf_alu_grants=2, perf_forced_grants=2.
